priority_arbiter: RTL and testbench

PRIORITY_ARBITER -- requirements
Module: priority_arbiter

---
 rtl/priority_arbiter_pkg.sv | 12 +
 rtl/priority_arbiter_prio_pick.sv | 28 ++
 rtl/priority_arbiter.sv | 120 ++++++++++++
 tb/tb_priority_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/priority_arbiter_pkg.sv
// rtl/priority_arbiter_pkg.sv - shared state encoding and arbitration mode constants
package priority_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int FIXED = 0;
    localparam int RR    = 1;

endpackage

// File: rtl/priority_arbiter_prio_pick.sv
// rtl/priority_arbiter_prio_pick.sv - combinational first-set-bit search starting at a pointer, wrapping
module prio_pick #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    output logic [W-1:0] winner_o,
    output logic         found_o
);

    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        for (int k = 0; k < N; k++) begin
            int pos;
            pos = int'(start_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found_o && req_i[pos]) begin
                found_o  = 1'b1;
                winner_o = W'(pos);
            end
        end
    end

endmodule

// File: rtl/priority_arbiter.sv
// rtl/priority_arbiter.sv - two-state request arbiter, fixed-priority or round-robin, with bounded grant length
module priority_arbiter
    import priority_arbiter_pkg::*;
#(
    parameter int N        = 8,
    parameter int MODE     = 0,
    parameter int MAX_HOLD = 16,
    parameter int W        = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         valid
);

    state_e         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [W-1:0]   idx_q, idx_d;
    logic           valid_q, valid_d;
    logic [W-1:0]   ptr_q, ptr_d;
    logic [7:0]     hold_q, hold_d;

    logic [N-1:0]   req_rev;
    logic [N-1:0]   pick_req;
    logic [W-1:0]   pick_start;
    logic [W-1:0]   pick_idx;
    logic           pick_found;
    logic [W-1:0]   win;
    logic [W-1:0]   nxt_ptr;
    logic           release_now;

    // Fixed priority reuses the upward search on the bit-reversed vector from 0,
    // so the first hit maps back to the highest set index.
    always_comb begin
        req_rev = '0;
        for (int i = 0; i < N; i++) begin
            req_rev[i] = req[N-1-i];
        end
    end

    assign pick_req   = (MODE == RR) ? req : req_rev;
    assign pick_start = (MODE == RR) ? ptr_q : '0;

    prio_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req_i    (pick_req),
        .start_i  (pick_start),
        .winner_o (pick_idx),
        .found_o  (pick_found)
    );

    assign win         = (MODE == RR) ? pick_idx : (W'(N - 1) - pick_idx);
    assign nxt_ptr     = (win == W'(N - 1)) ? '0 : (win + W'(1));
    assign release_now = ack || !req[idx_q] || (hold_q == 8'(MAX_HOLD - 1));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    gnt_d   = N'(1) << win;
                    idx_d   = win;
                    valid_d = 1'b1;
                    hold_d  = 8'd0;
                    if (MODE == RR) begin
                        ptr_d = nxt_ptr;
                    end
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    hold_d  = 8'd0;
                end else begin
                    hold_d  = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt   = gnt_q;
    assign idx   = idx_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// tb/tb_priority_arbiter.sv - directed vector bench for fixed-priority and round-robin arbiters
module tb_priority_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       ack;
    logic [3:0] gnt_f, gnt_r;
    logic [1:0] idx_f, idx_r;
    logic       valid_f, valid_r;

    int n_vec;
    int n_err;

    priority_arbiter #(.N(4), .MODE(0), .MAX_HOLD(4)) u_fix (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .ack   (ack),
        .gnt   (gnt_f),
        .idx   (idx_f),
        .valid (valid_f)
    );

    priority_arbiter #(.N(4), .MODE(1), .MAX_HOLD(4)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .ack   (ack),
        .gnt   (gnt_r),
        .idx   (idx_r),
        .valid (valid_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       ack;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic [3:0] r, input logic a);
        req = r;
        ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fix(input string name, input logic [3:0] g, input logic [1:0] i, input logic v);
        chk({name, ".gnt"},   {4'h0, gnt_f}, {4'h0, g});
        chk({name, ".idx"},   {6'h0, idx_f}, {6'h0, i});
        chk({name, ".valid"}, {7'h0, valid_f}, {7'h0, v});
    endtask

    task automatic chk_rr(input string name, input logic [3:0] g, input logic [1:0] i, input logic v);
        chk({name, ".gnt"},   {4'h0, gnt_r}, {4'h0, g});
        chk({name, ".idx"},   {6'h0, idx_r}, {6'h0, i});
        chk({name, ".valid"}, {7'h0, valid_r}, {7'h0, v});
    endtask

    // Structural invariants on both instances, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("fix.onehot", {7'h0, $onehot0(gnt_f)}, 8'h1);
            chk("fix.gnt_idx", {7'h0, gnt_f[idx_f]}, {7'h0, valid_f});
            chk("rr.onehot", {7'h0, $onehot0(gnt_r)}, 8'h1);
            chk("rr.gnt_idx", {7'h0, gnt_r[idx_r]}, {7'h0, valid_r});
        end
    end

    initial begin
        logic [1:0] rr_order [5];
        n_vec = 0;
        n_err = 0;
        rr_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Fixed-priority rows: inputs before the edge, registered outputs after it.
        tbl = '{
            '{4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1},
            '{4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1},
            '{4'b0110, 1'b1, 4'b0000, 2'd0, 1'b0},
            '{4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1},
            '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0},
            '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0},
            '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1},
            '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1},
            '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1},
            '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1},
            '{4'b1000, 1'b0, 4'b0000, 2'd0, 1'b0},
            '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1},
            '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0},
            '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1},
            '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1},
            '{4'b1000, 1'b0, 4'b0000, 2'd0, 1'b0},
            '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1},
            '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0},
            '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1},
            '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0},
            '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0}
        };

        rst_n = 1'b0;
        req   = 4'b0000;
        ack   = 1'b0;
        #12;
        chk_fix("reset_fix", 4'b0000, 2'd0, 1'b0);
        chk_rr("reset_rr", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int c = 0; c < 5; c++) begin
            apply(4'b0000, 1'b0);
            chk_fix("idle_fix", 4'b0000, 2'd0, 1'b0);
            chk_rr("idle_rr", 4'b0000, 2'd0, 1'b0);
        end

        for (int i = 0; i < 21; i++) begin
            apply(tbl[i].req, tbl[i].ack);
            chk_fix($sformatf("tbl%0d", i), tbl[i].gnt, tbl[i].idx, tbl[i].valid);
        end

        // Round-robin: requester 0 held through a forced release loses to requester 1.
        apply(4'b0000, 1'b0);
        apply(4'b0001, 1'b0);
        chk_rr("rr_hold_g0", 4'b0001, 2'd0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            apply(4'b0011, 1'b0);
            chk_rr("rr_hold_keep", 4'b0001, 2'd0, 1'b1);
        end
        apply(4'b0011, 1'b0);
        chk_rr("rr_forced_rel", 4'b0000, 2'd0, 1'b0);
        apply(4'b0011, 1'b0);
        chk_rr("rr_next_wins", 4'b0010, 2'd1, 1'b1);

        // Asynchronous reset mid-grant, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk_rr("async_rst_rr", 4'b0000, 2'd0, 1'b0);
        chk_fix("async_rst_fix", 4'b0000, 2'd0, 1'b0);
        #1;
        rst_n = 1'b1;

        // With the pointer back at 0 the round-robin order restarts from requester 0.
        for (int k = 0; k < 5; k++) begin
            apply(4'b1111, 1'b0);
            chk_rr($sformatf("rr_order%0d", k), 4'(1 << rr_order[k]), rr_order[k], 1'b1);
            apply(4'b1111, 1'b1);
            chk_rr($sformatf("rr_gap%0d", k), 4'b0000, 2'd0, 1'b0);
        end

        apply(4'b0000, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
